// File: rtl/mips_data_mem_if.sv
// CPU <-> data memory bus: request signals from the CPU, read data and status back.
interface mips_data_mem_if;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [3:0]  byte_enable;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic        ready;
  logic        err;
  logic [15:0] read_count;
  logic [15:0] write_count;

  modport master (
    output data_address, data_read, data_write, byte_enable, data_writedata,
    input  data_readdata, ready, err, read_count, write_count
  );

  modport slave (
    input  data_address, data_read, data_write, byte_enable, data_writedata,
    output data_readdata, ready, err, read_count, write_count
  );
endinterface

// File: rtl/mips_data_mem.sv
// Word-addressed data memory with byte-lane writes, combinational reads, a self-clearing
// start-up phase, saturating access counters and a sticky out-of-range flag.
module mips_data_mem #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000
) (
  input  logic             clk,
  input  logic             reset,
  mips_data_mem_if.slave   bus
);

  localparam int unsigned Depth   = 2 ** DEPTH_LOG2;
  localparam logic [31:0] EndAddr = BASE_ADDR + 32'(4 * Depth);

  typedef enum logic {StClear, StReady} state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] clear_idx_q, clear_idx_d;
  logic                  err_q, err_d;
  logic [15:0]           rd_cnt_q, rd_cnt_d;
  logic [15:0]           wr_cnt_q, wr_cnt_d;
  logic [31:0]           mem_q [Depth];

  logic                  ready;
  logic                  in_range;
  logic [31:0]           offset;
  logic [DEPTH_LOG2-1:0] index;
  logic                  rd_acc, wr_acc;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_widx;
  logic [31:0]           mem_wdata;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StClear;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StClear: if (clear_idx_q == DEPTH_LOG2'(Depth - 1)) state_d = StReady;
      StReady: state_d = StReady;
      default: state_d = StClear;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready = (state_q == StReady);
  end

  // Address decode and request acceptance
  always_comb begin
    in_range = (bus.data_address >= BASE_ADDR) && (bus.data_address < EndAddr);
    offset   = bus.data_address - BASE_ADDR;
    index    = DEPTH_LOG2'(offset >> 2);
    rd_acc   = ready && bus.data_read  && in_range;
    wr_acc   = ready && bus.data_write && in_range;
  end

  // Datapath next-state: clear pointer, counters, sticky error
  always_comb begin
    clear_idx_d = clear_idx_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    err_d       = err_q;
    if (state_q == StClear) clear_idx_d = clear_idx_q + 1'b1;
    if (rd_acc && (rd_cnt_q != 16'hFFFF)) rd_cnt_d = rd_cnt_q + 16'd1;
    if (wr_acc && (wr_cnt_q != 16'hFFFF)) wr_cnt_d = wr_cnt_q + 16'd1;
    if (ready && (bus.data_read || bus.data_write) && !in_range) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clear_idx_q <= '0;
      err_q       <= 1'b0;
      rd_cnt_q    <= 16'd0;
      wr_cnt_q    <= 16'd0;
    end else begin
      clear_idx_q <= clear_idx_d;
      err_q       <= err_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

  // One write port shared by the clearing sweep and CPU writes; lanes merged into the old word
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = index;
    mem_wdata = '0;
    if (state_q == StClear) begin
      mem_we   = 1'b1;
      mem_widx = clear_idx_q;
    end else if (wr_acc) begin
      mem_we = 1'b1;
      for (int i = 0; i < 4; i++) begin
        mem_wdata[8*i +: 8] = bus.byte_enable[i] ? bus.data_writedata[8*i +: 8]
                                                 : mem_q[index][8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_widx] <= mem_wdata;
  end

  // Outputs
  always_comb begin
    bus.data_readdata = rd_acc ? mem_q[index] : 32'h0;
    bus.ready         = ready;
    bus.err           = err_q;
    bus.read_count    = rd_cnt_q;
    bus.write_count   = wr_cnt_q;
  end

endmodule
